// File: rtl/axi_slave0_wr_master.sv
// AXI4 write initiator for the Slave 0 window: range-checks one burst command, runs AW/W/B, returns one status.
// Optional B-channel timeout is compiled in with `define AXI_WR_MASTER_TIMEOUT_EN.
module axi_slave0_wr_master #(
   parameter logic [31:0] S0_BASE     = 32'h0000_0000,
   parameter logic [31:0] S0_END      = 32'h0000_0FFF,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_len,
   input  logic [5:0]  cmd_id,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic        rsp_valid,
   output logic [1:0]  rsp_resp,
   output logic [5:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [5:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {IDLE, CHK, XFER, RESP_WAIT, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q;
   logic [7:0]  len_q;
   logic [5:0]  id_q;
   logic [7:0]  beat_cnt;
   logic        aw_done, w_done;
   logic [1:0]  rsp_resp_nx;
   logic [32:0] span, last_byte, base_diff;
   logic        range_ok, w_open, w_hs, b_timeout;

   // 33-bit arithmetic: a carry out of the end address or a borrow below the base both fail the check
   assign span      = ({25'd0, len_q} + 33'd1) << 2;
   assign last_byte = {1'b0, addr_q} + span - 33'd1;
   assign base_diff = {1'b0, addr_q} - {1'b0, S0_BASE};
   assign range_ok  = (addr_q[1:0] == 2'b00) && !base_diff[32] && (last_byte <= {1'b0, S0_END});

   assign w_open    = (state == XFER) && !w_done;
   assign cmd_ready = (state == IDLE);
   assign awvalid   = (state == XFER) && !aw_done;
   assign awid      = id_q;
   assign awaddr    = addr_q;
   assign awlen     = len_q;
   assign awsize    = 3'b010;
   assign awburst   = 2'b01;
   assign wvalid    = w_open && wr_valid;
   assign wr_ready  = w_open && wready;
   assign wdata     = wr_data;
   assign wstrb     = wr_strb;
   assign wlast     = w_open && (beat_cnt == len_q);
   assign w_hs      = wvalid && wready;
   assign bready    = (state == RESP_WAIT);
   assign rsp_valid = (state == DONE);

`ifdef AXI_WR_MASTER_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [TCNT_W-1:0] tcnt;

   // tcnt counts completed RESP_WAIT cycles; it restarts from zero on every entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tcnt <= '0;
      else if (state != RESP_WAIT)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

   assign b_timeout = (tcnt == TCNT_W'(TIMEOUT_CYC - 1));
`else
   assign b_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nx    = state;
      rsp_resp_nx = rsp_resp;
      case (state)
         IDLE:      if (cmd_valid) state_nx = CHK;
         CHK: begin
            if (range_ok) begin
               state_nx = XFER;
            end else begin
               state_nx    = DONE;
               rsp_resp_nx = 2'b11;
            end
         end
         XFER:      if (aw_done && w_done) state_nx = RESP_WAIT;
         RESP_WAIT: begin
            if (bvalid) begin
               state_nx    = DONE;
               rsp_resp_nx = (bid != id_q) ? 2'b10 : bresp;
            end else if (b_timeout) begin
               state_nx    = DONE;
               rsp_resp_nx = 2'b10;
            end
         end
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         beat_cnt <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         rsp_resp <= 2'b00;
      end else begin
         rsp_resp <= rsp_resp_nx;
         if (state == IDLE && cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            id_q     <= cmd_id;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
         end
         if (awvalid && awready)
            aw_done <= 1'b1;
         if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (wlast)
               w_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_slave0_wr_master.sv
// Directed bench for axi_slave0_wr_master; timeout step runs when AXI_WR_MASTER_TIMEOUT_EN is defined.
module tb_axi_slave0_wr_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [5:0]  cmd_id;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_resp;
   logic [5:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [5:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int vectors     = 0;
   int miscompares = 0;

   axi_slave0_wr_master #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rsp_valid(rsp_valid), .rsp_resp(rsp_resp),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one command and plays an ideal slave: awready after aw_delay cycles of awvalid,
   // wready always high, optional wr_valid bubble, B sent the cycle after AW and last W both complete.
   task automatic do_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [5:0] id,
                         input int aw_delay, input int bubble_cyc, input bit send_b,
                         input logic [5:0] b_id, input logic [1:0] b_resp, input logic [31:0] data_base,
                         output int lat, output logic [1:0] resp, output int aw_hs,
                         output int w_beats, output int awv_cyc, output int rw_cyc);
      int   cyc;
      int   beat;
      bit   w_seen, b_pend, b_sent, done;
      logic [3:0] strb_exp;
      cyc = 0; beat = 0; w_seen = 0; b_pend = 0; b_sent = 0; done = 0;
      aw_hs = 0; w_beats = 0; awv_cyc = 0; rw_cyc = 0; lat = 0; resp = 2'bxx;
      cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_id = id;
      awready = 1'b0; wready = 1'b0; wr_valid = 1'b0; bvalid = 1'b0;
      #1;
      check("cmd_ready_idle", cmd_ready, 1'b1);
      while (!done && cyc < 300) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         cyc++;
         awready  = (cyc >= 2 + aw_delay);
         wready   = 1'b1;
         wr_valid = (cyc != bubble_cyc);
         wr_data  = data_base + 32'(beat);
         strb_exp = 4'hF ^ 4'(beat);
         wr_strb  = strb_exp;
         bvalid   = b_pend;
         bid      = b_id;
         bresp    = b_resp;
         #1;
         if (rsp_valid) begin
            resp = rsp_resp;
            lat  = cyc;
            done = 1;
         end else begin
            if (awvalid) begin
               awv_cyc++;
               check("awaddr", awaddr, addr);
               check("awlen", awlen, len);
               check("awid", awid, id);
               if (awready) begin
                  aw_hs++;
                  check("awsize", awsize, 3'b010);
                  check("awburst", awburst, 2'b01);
               end
            end
            if (wvalid && wready) begin
               check("wlast", wlast, (beat == int'(len)));
               check("wdata", wdata, data_base + 32'(beat));
               check("wstrb", wstrb, strb_exp);
               if (wlast) w_seen = 1;
               beat++;
               w_beats++;
            end
            if (bready) begin
               rw_cyc++;
               if (bvalid) b_pend = 0;
            end
            if (aw_hs > 0 && w_seen && send_b && !b_sent) begin
               b_pend = 1;
               b_sent = 1;
            end
         end
      end
      check("rsp_within_budget", done, 1'b1);
      awready = 1'b0; wready = 1'b0; wr_valid = 1'b0; bvalid = 1'b0;
      @(posedge clk); #1;
      check("rsp_valid_one_cycle", rsp_valid, 1'b0);
      check("cmd_ready_after_done", cmd_ready, 1'b1);
      check("rsp_resp_holds", rsp_resp, resp);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, aw_hs, w_beats, awv_cyc, rw_cyc;
      logic [1:0] resp;
      bit rsp_seen;

      rst = 1'b1;
      cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 0;
      awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
      #12;
      check("rst_awvalid", awvalid, 1'b0);
      check("rst_wvalid", wvalid, 1'b0);
      check("rst_bready", bready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_wlast", wlast, 1'b0);
      check("rst_rsp_resp", rsp_resp, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("cmd_ready_after_rst", cmd_ready, 1'b1);

      // single beat, zero-wait slave: rsp_valid in the 5th cycle after the command handshake
      do_cmd(32'h100, 8'd0, 6'd5, 0, 0, 1, 6'd5, 2'b00, 32'hA5A5_0001,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("single_latency", lat, 5);
      check("single_resp", resp, 2'b00);
      check("single_aw_hs", aw_hs, 1);
      check("single_beats", w_beats, 1);

      // 4-beat burst ending at 0xFFF, awready 4 cycles late, a W bubble on cycle 3
      do_cmd(32'hFF0, 8'd3, 6'd12, 4, 3, 1, 6'd12, 2'b00, 32'h1000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("burst_resp", resp, 2'b00);
      check("burst_beats", w_beats, 4);
      check("burst_aw_hs", aw_hs, 1);
      check("burst_awvalid_cycles", awv_cyc, 5);
      check("burst_latency", lat, 9);

      // out of window
      do_cmd(32'h1000, 8'd0, 6'd1, 0, 0, 1, 6'd1, 2'b00, 32'h0,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("oor_resp", resp, 2'b11);
      check("oor_no_aw", awv_cyc, 0);
      check("oor_no_w", w_beats, 0);
      check("oor_latency", lat, 2);

      // crosses 0xFFF
      do_cmd(32'hFFC, 8'd1, 6'd2, 0, 0, 1, 6'd2, 2'b00, 32'h0,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("cross_resp", resp, 2'b11);
      check("cross_no_aw", awv_cyc, 0);

      // misaligned
      do_cmd(32'h102, 8'd0, 6'd3, 0, 0, 1, 6'd3, 2'b00, 32'h0,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("misalign_resp", resp, 2'b11);
      check("misalign_no_w", w_beats, 0);

      // B with wrong ID
      do_cmd(32'h200, 8'd1, 6'd5, 0, 0, 1, 6'd6, 2'b00, 32'h2000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("bad_bid_resp", resp, 2'b10);
      check("bad_bid_beats", w_beats, 2);

      // slave returns SLVERR, then EXOKAY, with matching ID
      do_cmd(32'h300, 8'd0, 6'd5, 1, 0, 1, 6'd5, 2'b10, 32'h3000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("slverr_resp", resp, 2'b10);
      do_cmd(32'h0, 8'd0, 6'd63, 0, 0, 1, 6'd63, 2'b01, 32'h4000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("exokay_resp", resp, 2'b01);
      check("base_addr_aw_hs", aw_hs, 1);

      // reset during beat 2 of a len=3 burst, AW still pending
      cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_len = 8'd3; cmd_id = 6'd9;
      awready = 1'b0; wready = 1'b1; wr_valid = 1'b1; wr_strb = 4'hF; wr_data = 32'h5555_0000;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("pre_rst_awvalid", awvalid, 1'b1);
      check("pre_rst_wvalid", wvalid, 1'b1);
      rst = 1'b1;
      #1;
      check("async_rst_awvalid", awvalid, 1'b0);
      check("async_rst_wvalid", wvalid, 1'b0);
      check("async_rst_bready", bready, 1'b0);
      check("async_rst_wr_ready", wr_ready, 1'b0);
      wr_valid = 1'b0; wready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      rsp_seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid || awvalid) rsp_seen = 1;
      end
      check("abandoned_no_activity", rsp_seen, 1'b0);
      check("rst_clears_resp", rsp_resp, 2'b00);
      do_cmd(32'h500, 8'd2, 6'd7, 2, 0, 1, 6'd7, 2'b00, 32'h6000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("post_rst_resp", resp, 2'b00);
      check("post_rst_beats", w_beats, 3);

`ifdef AXI_WR_MASTER_TIMEOUT_EN
      // B withheld: 16 RESP_WAIT cycles with bready, then SLVERR and bready low
      do_cmd(32'h600, 8'd0, 6'd4, 0, 0, 0, 6'd4, 2'b00, 32'h7000_0000,
             lat, resp, aw_hs, w_beats, awv_cyc, rw_cyc);
      check("timeout_resp", resp, 2'b10);
      check("timeout_wait_cycles", rw_cyc, 16);
      check("timeout_bready_low", bready, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
